// File: rtl/branch_pc_ctrl.sv
// Bundle PC sequencer and branch redirect controller for the VLIW front end.
// Optional redirect/bubble statistics outputs are enabled by defining BRANCH_PC_CTRL_STATS_EN.
module branch_pc_ctrl #(
    parameter int          NUM_BR        = 2,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          BUNDLE_BYTES  = 16,
    parameter int          BUBBLE_CYCLES = 1,
    localparam int         LW            = (NUM_BR > 1) ? $clog2(NUM_BR) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic [NUM_BR-1:0]   br_taken,
    input  logic [32*NUM_BR-1:0] br_target,
    output logic [31:0]         fetch_pc,
    output logic                fetch_valid,
    output logic                squash,
    output logic [LW-1:0]       redirect_lane,
    output logic                br_misalign
`ifdef BRANCH_PC_CTRL_STATS_EN
    ,
    output logic [31:0]         redirect_count,
    output logic [31:0]         bubble_count
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    localparam logic [31:0] ALIGN_MASK  = 32'(BUNDLE_BYTES - 1);
    localparam logic [31:0] PC_STEP     = 32'(BUNDLE_BYTES);
    localparam logic [2:0]  BUBBLE_LOAD = 3'(BUBBLE_CYCLES);

    state_t         state_r;
    state_t         state_s;
    logic [31:0]    pc_r;
    logic [31:0]    pc_s;
    logic [2:0]     cnt_r;
    logic [2:0]     cnt_s;
    logic           shadow_r;
    logic           shadow_s;

    logic           any_taken_s;
    logic [LW-1:0]  win_lane_s;
    logic [31:0]    win_target_s;
    logic           accept_s;

    // Fixed-priority pick: scanning from the top down lets the lowest (oldest) lane win.
    always_comb begin
        any_taken_s  = 1'b0;
        win_lane_s   = '0;
        win_target_s = 32'h0000_0000;
        for (int i = NUM_BR - 1; i >= 0; i--) begin
            if (br_taken[i]) begin
                any_taken_s  = 1'b1;
                win_lane_s   = LW'(i);
                win_target_s = br_target[32*i +: 32];
            end else begin
                any_taken_s  = any_taken_s;
            end
        end
    end

    // The EX stage right behind a redirect holds the squashed bundle, hence the shadow gate.
    assign accept_s = any_taken_s & ~stall & ~shadow_r & (state_r != ST_BOOT);

    // Combinational redirect indication, live in the accept cycle itself.
    always_comb begin
        squash        = accept_s;
        br_misalign   = 1'b0;
        redirect_lane = '0;
        if (accept_s) begin
            redirect_lane = win_lane_s;
            br_misalign   = |(win_target_s & ALIGN_MASK);
        end else begin
            redirect_lane = '0;
        end
    end

    assign fetch_valid = (state_r == ST_RUN);
    assign fetch_pc    = pc_r;

    // Next-state, PC and bubble sequencing.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        cnt_s    = cnt_r;
        shadow_s = shadow_r;
        if (stall) begin
            state_s = state_r;
        end else if (accept_s) begin
            pc_s     = win_target_s & ~ALIGN_MASK;
            shadow_s = 1'b1;
            if (BUBBLE_CYCLES == 0) begin
                state_s = ST_RUN;
                cnt_s   = 3'd0;
            end else begin
                state_s = ST_BUBBLE;
                cnt_s   = BUBBLE_LOAD;
            end
        end else begin
            shadow_s = 1'b0;
            case (state_r)
                ST_BOOT: begin
                    state_s = ST_RUN;
                end
                ST_RUN: begin
                    pc_s = pc_r + PC_STEP;
                end
                ST_BUBBLE: begin
                    // Exit cycle does not advance the PC: the held target is fetched next.
                    if (cnt_r <= 3'd1) begin
                        cnt_s   = 3'd0;
                        state_s = ST_RUN;
                    end else begin
                        cnt_s   = cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_s = ST_BOOT;
                    pc_s    = RESET_PC;
                    cnt_s   = 3'd0;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_BOOT;
            pc_r     <= RESET_PC;
            cnt_r    <= 3'd0;
            shadow_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            cnt_r    <= cnt_s;
            shadow_r <= shadow_s;
        end
    end

`ifdef BRANCH_PC_CTRL_STATS_EN
    logic [31:0] redirect_cnt_r;
    logic [31:0] bubble_cnt_r;

    // Saturating statistics counters; frozen while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_r <= 32'h0000_0000;
            bubble_cnt_r   <= 32'h0000_0000;
        end else if (!stall) begin
            if (accept_s && (redirect_cnt_r != 32'hFFFF_FFFF)) begin
                redirect_cnt_r <= redirect_cnt_r + 32'd1;
            end else begin
                redirect_cnt_r <= redirect_cnt_r;
            end
            if ((state_r == ST_BUBBLE) && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
        end else begin
            redirect_cnt_r <= redirect_cnt_r;
            bubble_cnt_r   <= bubble_cnt_r;
        end
    end

    assign redirect_count = redirect_cnt_r;
    assign bubble_count   = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Scoreboard bench for branch_pc_ctrl with default parameters (2 lanes, 16-byte bundles, 1 bubble).
module tb_branch_pc_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  br_taken;
    logic [63:0] br_target;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        squash;
    logic [0:0]  redirect_lane;
    logic        br_misalign;
`ifdef BRANCH_PC_CTRL_STATS_EN
    logic [31:0] redirect_count;
    logic [31:0] bubble_count;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        sq;
        logic        lane;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    branch_pc_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .fetch_pc      (fetch_pc),
        .fetch_valid   (fetch_valid),
        .squash        (squash),
        .redirect_lane (redirect_lane),
        .br_misalign   (br_misalign)
`ifdef BRANCH_PC_CTRL_STATS_EN
        ,
        .redirect_count(redirect_count),
        .bubble_count  (bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive inputs, push the expectation, compare at the falling edge.
    task automatic cyc(input string tag, input logic st, input logic [1:0] tk,
                       input logic [31:0] t0, input logic [31:0] t1,
                       input logic [31:0] epc, input logic ev, input logic esq,
                       input logic elane, input logic emis);
        exp_t e;
        exp_t got;
        stall     = st;
        br_taken  = tk;
        br_target = {t1, t0};
        e = '{pc: epc, valid: ev, sq: esq, lane: elane, mis: emis};
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        total++;
        if (fetch_pc !== got.pc) begin
            bad++;
            $display("FAIL %s fetch_pc got=%h exp=%h", tag, fetch_pc, got.pc);
        end
        total++;
        if (fetch_valid !== got.valid) begin
            bad++;
            $display("FAIL %s fetch_valid got=%b exp=%b", tag, fetch_valid, got.valid);
        end
        total++;
        if (squash !== got.sq) begin
            bad++;
            $display("FAIL %s squash got=%b exp=%b", tag, squash, got.sq);
        end
        total++;
        if (br_misalign !== got.mis) begin
            bad++;
            $display("FAIL %s br_misalign got=%b exp=%b", tag, br_misalign, got.mis);
        end
        if (got.sq) begin
            total++;
            if (redirect_lane !== got.lane) begin
                bad++;
                $display("FAIL %s redirect_lane got=%0d exp=%0d", tag, redirect_lane, got.lane);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; br_taken = 2'b00; br_target = 64'd0;
        #1;
        total++;
        if (fetch_pc !== 32'h0 || fetch_valid !== 1'b0 || squash !== 1'b0 || br_misalign !== 1'b0) begin
            bad++;
            $display("FAIL reset_values pc=%h v=%b sq=%b mis=%b exp pc=0 v=0 sq=0 mis=0",
                     fetch_pc, fetch_valid, squash, br_misalign);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cyc("boot",  1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("run0",  1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("run1",  1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("run2",  1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lane1_redirect();
        cyc("l1_acc",  1'b0, 2'b10, 32'h0, 32'h400, 32'h0000_0030, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("l1_bub",  1'b0, 2'b00, 32'h0, 32'h0,   32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("l1_tgt",  1'b0, 2'b00, 32'h0, 32'h0,   32'h0000_0400, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("l1_next", 1'b0, 2'b00, 32'h0, 32'h0,   32'h0000_0410, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        cyc("pri_acc", 1'b0, 2'b11, 32'h100, 32'h200, 32'h0000_0420, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("pri_bub", 1'b0, 2'b00, 32'h0,   32'h0,   32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("pri_tgt", 1'b0, 2'b00, 32'h0,   32'h0,   32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_shadow();
        cyc("shd_acc",  1'b0, 2'b01, 32'h500, 32'h0, 32'h0000_0110, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("shd_ign",  1'b0, 2'b01, 32'h900, 32'h0, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("shd_tgt",  1'b0, 2'b00, 32'h0,   32'h0, 32'h0000_0500, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("shd_next", 1'b0, 2'b00, 32'h0,   32'h0, 32'h0000_0510, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            cyc("stl_hold", 1'b1, 2'b01, 32'h80, 32'h0, 32'h0000_0520, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cyc("stl_acc", 1'b0, 2'b01, 32'h80, 32'h0, 32'h0000_0520, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("stl_bub", 1'b0, 2'b00, 32'h0,  32'h0, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("stl_tgt", 1'b0, 2'b00, 32'h0,  32'h0, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_misalign();
        cyc("mis_acc", 1'b0, 2'b01, 32'h1234, 32'h0, 32'h0000_0090, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("mis_bub", 1'b0, 2'b00, 32'h0,    32'h0, 32'h0000_1230, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("mis_tgt", 1'b0, 2'b00, 32'h0,    32'h0, 32'h0000_1230, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        cyc("wrp_acc", 1'b0, 2'b10, 32'h0, 32'hFFFF_FFF0, 32'h0000_1240, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("wrp_bub", 1'b0, 2'b00, 32'h0, 32'h0,         32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("wrp_top", 1'b0, 2'b00, 32'h0, 32'h0,         32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("wrp_zero",1'b0, 2'b00, 32'h0, 32'h0,         32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("wrp_next",1'b0, 2'b00, 32'h0, 32'h0,         32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        cyc("b2b_acc1", 1'b0, 2'b01, 32'h600, 32'h0,   32'h0000_0020, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("b2b_shd",  1'b0, 2'b01, 32'h700, 32'h0,   32'h0000_0600, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("b2b_acc2", 1'b0, 2'b10, 32'h0,   32'h800, 32'h0000_0600, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("b2b_bub",  1'b0, 2'b00, 32'h0,   32'h0,   32'h0000_0800, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("b2b_tgt",  1'b0, 2'b00, 32'h0,   32'h0,   32'h0000_0800, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_bubble();
        cyc("rb_acc", 1'b0, 2'b01, 32'h300, 32'h0, 32'h0000_0810, 1'b1, 1'b1, 1'b0, 1'b0);
        br_taken = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (fetch_pc !== 32'h0 || fetch_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_bubble pc=%h v=%b exp pc=00000000 v=0", fetch_pc, fetch_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("rb_boot", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rb_run",  1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("rb_next", 1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_lane1_redirect();
        test_priority();
        test_shadow();
        test_stall();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_reset_in_bubble();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
